// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, mul/div results queue and drain into idle slots.
// Optional macro RF_WB_BYPASS_EN lets a mul/div result skip the empty FIFO straight to the write port.
module rf_wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     PIPE_WB_VALID,
    input  logic [4:0]               PIPE_WB_DES,
    input  logic [31:0]              PIPE_WB_DATA,
    input  logic                     LL_VALID,
    input  logic [4:0]               LL_DES,
    input  logic [31:0]              LL_DATA,
    output logic                     LL_READY,
    output logic                     WB_VALID,
    output logic [4:0]               WB_DES,
    output logic [31:0]              WB_DATA,
    output logic                     STARVE_HOLD,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STARVE_W = 8;

    logic [4:0]          mem_des  [DEPTH];
    logic [31:0]         mem_data [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [STARVE_W-1:0] starve_cnt;

    logic                ll_take;
    logic                fifo_empty;
    logic                bypass;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    count_nxt;
    logic [STARVE_W-1:0] starve_nxt;
    logic                wb_valid_nxt;
    logic [4:0]          wb_des_nxt;
    logic [31:0]         wb_data_nxt;

    // Handshake, push/pop decisions and write-port selection
    always_comb begin
        LL_READY     = !RST && (FIFO_COUNT != CNT_W'(DEPTH));
        ll_take      = LL_VALID && LL_READY;
        fifo_empty   = (FIFO_COUNT == '0);
        bypass       = 1'b0;
`ifdef RF_WB_BYPASS_EN
        bypass       = fifo_empty && !PIPE_WB_VALID && ll_take && (LL_DES != 5'd0);
`endif
        push         = ll_take && (LL_DES != 5'd0) && !bypass;
        pop          = !PIPE_WB_VALID && !fifo_empty;

        count_nxt    = FIFO_COUNT;
        if (push && !pop) begin
            count_nxt = FIFO_COUNT + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = FIFO_COUNT - CNT_W'(1);
        end

        starve_nxt   = starve_cnt;
        if (pop || fifo_empty) begin
            starve_nxt = '0;
        end else if (PIPE_WB_VALID && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
            starve_nxt = starve_cnt + STARVE_W'(1);
        end

        wb_valid_nxt = 1'b0;
        wb_des_nxt   = WB_DES;
        wb_data_nxt  = WB_DATA;
        if (PIPE_WB_VALID) begin
            wb_valid_nxt = (PIPE_WB_DES != 5'd0);
            wb_des_nxt   = PIPE_WB_DES;
            wb_data_nxt  = PIPE_WB_DATA;
        end else if (pop) begin
            wb_valid_nxt = 1'b1;
            wb_des_nxt   = mem_des[rd_ptr];
            wb_data_nxt  = mem_data[rd_ptr];
        end else if (bypass) begin
            wb_valid_nxt = 1'b1;
            wb_des_nxt   = LL_DES;
            wb_data_nxt  = LL_DATA;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the count
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_des[wr_ptr]  <= LL_DES;
            mem_data[wr_ptr] <= LL_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            FIFO_COUNT  <= '0;
            starve_cnt  <= '0;
            STARVE_HOLD <= 1'b0;
            WB_VALID    <= 1'b0;
            WB_DES      <= '0;
            WB_DATA     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            FIFO_COUNT  <= count_nxt;
            starve_cnt  <= starve_nxt;
            STARVE_HOLD <= (starve_nxt == STARVE_W'(STARVE_LIMIT));
            WB_VALID    <= wb_valid_nxt;
            WB_DES      <= wb_des_nxt;
            WB_DATA     <= wb_data_nxt;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_rf_wb_arbiter;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int unsigned CW           = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_valid;
    logic [4:0]    pipe_des;
    logic [31:0]   pipe_data;
    logic          ll_valid;
    logic [4:0]    ll_des;
    logic [31:0]   ll_data;
    logic          ll_ready;
    logic          wb_valid;
    logic [4:0]    wb_des;
    logic [31:0]   wb_data;
    logic          starve_hold;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [36:0] q[$];
    int          starve   = 0;
    logic        exp_valid = 1'b0;
    logic [4:0]  exp_des   = '0;
    logic [31:0] exp_data  = '0;
    logic        exp_hold  = 1'b0;
    logic        exp_ready;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK(clk), .RST(rst),
        .PIPE_WB_VALID(pipe_valid), .PIPE_WB_DES(pipe_des), .PIPE_WB_DATA(pipe_data),
        .LL_VALID(ll_valid), .LL_DES(ll_des), .LL_DATA(ll_data), .LL_READY(ll_ready),
        .WB_VALID(wb_valid), .WB_DES(wb_des), .WB_DATA(wb_data),
        .STARVE_HOLD(starve_hold), .FIFO_COUNT(fifo_count)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the currently driven inputs
    task automatic model_cycle();
        logic        was_empty;
        logic        popped;
        logic        bypassed;
        logic [36:0] e;
        if (rst) begin
            q.delete();
            starve    = 0;
            exp_valid = 1'b0;
            exp_des   = '0;
            exp_data  = '0;
            exp_hold  = 1'b0;
            return;
        end
        was_empty = (q.size() == 0);
        popped    = 1'b0;
        bypassed  = 1'b0;
        if (pipe_valid) begin
            exp_valid = (pipe_des != 5'd0);
            exp_des   = pipe_des;
            exp_data  = pipe_data;
        end else if (q.size() > 0) begin
            e         = q.pop_front();
            exp_valid = 1'b1;
            exp_des   = e[36:32];
            exp_data  = e[31:0];
            popped    = 1'b1;
        end else begin
            exp_valid = 1'b0;
`ifdef RF_WB_BYPASS_EN
            if (ll_valid && ll_des != 5'd0) begin
                exp_valid = 1'b1;
                exp_des   = ll_des;
                exp_data  = ll_data;
                bypassed  = 1'b1;
            end
`endif
        end
        if (ll_valid && exp_ready && ll_des != 5'd0 && !bypassed)
            q.push_back({ll_des, ll_data});
        if (popped || was_empty)
            starve = 0;
        else if (pipe_valid && starve < int'(STARVE_LIMIT))
            starve++;
        exp_hold = (starve == int'(STARVE_LIMIT));
    endtask

    // Settle inputs, capture the model's ready, then clock once and settle outputs
    task automatic tick();
        #1;
        exp_ready = !rst && (q.size() != int'(DEPTH));
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_valid = 1'b0; pipe_des = '0; pipe_data = '0;
        ll_valid   = 1'b0; ll_des   = '0; ll_data   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; ll_valid = 1'b1; ll_des = 5'd7; ll_data = 32'h1234_5678;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (ll_ready !== 1'b0) begin
                n_fail++; $display("FAIL reset_ll_ready cyc%0d got %b want 0", c, ll_ready);
            end
            tick();
            n_checks++;
            if (wb_valid !== 1'b0 || fifo_count !== '0 || starve_hold !== 1'b0 ||
                wb_des !== '0 || wb_data !== '0) begin
                n_fail++;
                $display("FAIL reset_state cyc%0d got v=%b cnt=%0d hold=%b des=%0d data=%h want all 0",
                         c, wb_valid, fifo_count, starve_hold, wb_des, wb_data);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_push();
        int   lat = 0;
        int   want_lat;
`ifdef RF_WB_BYPASS_EN
        want_lat = 1;
`else
        want_lat = 2;
`endif
        idle_inputs();
        ll_valid = 1'b1; ll_des = 5'd5; ll_data = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            ll_valid = 1'b0;
            if (wb_valid === 1'b1 && lat == 0) lat = c;
        end
        n_checks++;
        if (lat != want_lat) begin
            n_fail++; $display("FAIL single_push_latency got %0d want %0d", lat, want_lat);
        end
        n_checks++;
        if (wb_des !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_push_payload got des=%0d data=%h want 5 deadbeef", wb_des, wb_data);
        end
    endtask

    task automatic test_starve();
        logic [4:0]  pd [4];
        logic [31:0] pv [4];
        idle_inputs();
        pipe_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            pipe_des  = 5'($urandom_range(1, 31));
            pipe_data = $urandom;
            ll_valid  = (c < 4);
            if (c < 4) begin
                pd[c] = 5'($urandom_range(1, 31)); pv[c] = $urandom;
                ll_des = pd[c]; ll_data = pv[c];
            end
            tick();
            n_checks++;
            if (starve_hold !== exp_hold || fifo_count !== CW'(q.size()) || wb_des !== exp_des) begin
                n_fail++;
                $display("FAIL starve_fill cyc%0d got hold=%b cnt=%0d des=%0d want hold=%b cnt=%0d des=%0d",
                         c, starve_hold, fifo_count, wb_des, exp_hold, q.size(), exp_des);
            end
        end
        n_checks++;
        if (fifo_count !== CW'(4) || ll_ready !== 1'b0 || starve_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_full got cnt=%0d ready=%b hold=%b want 4 0 1", fifo_count, ll_ready, starve_hold);
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (wb_valid !== 1'b1 || wb_des !== pd[i] || wb_data !== pv[i] || starve_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_drain%0d got v=%b des=%0d data=%h hold=%b want 1 %0d %h 0",
                         i, wb_valid, wb_des, wb_data, starve_hold, pd[i], pv[i]);
            end
        end
        tick();
        n_checks++;
        if (wb_valid !== 1'b0 || fifo_count !== '0) begin
            n_fail++; $display("FAIL starve_empty got v=%b cnt=%0d want 0 0", wb_valid, fifo_count);
        end
    endtask

    task automatic test_full_pop();
        idle_inputs();
        pipe_valid = 1'b1; pipe_des = 5'd3; pipe_data = 32'h3;
        ll_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            ll_des = 5'(10 + c); ll_data = 32'(c);
            tick();
        end
        pipe_valid = 1'b0; ll_des = 5'd20; ll_data = 32'hAAAA_0020;
        #1;
        n_checks++;
        if (ll_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_pop_ready got %b want 0", ll_ready);
        end
        tick();
        n_checks++;
        if (fifo_count !== CW'(3) || wb_des !== 5'd10 || wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_pop_count got cnt=%0d des=%0d v=%b want 3 10 1", fifo_count, wb_des, wb_valid);
        end
        pipe_valid = 1'b1; ll_des = 5'd21; ll_data = 32'hAAAA_0021;
        #1;
        n_checks++;
        if (ll_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_refill_ready got %b want 1", ll_ready);
        end
        tick();
        n_checks++;
        if (fifo_count !== CW'(4)) begin
            n_fail++; $display("FAIL full_refill_count got %0d want 4", fifo_count);
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (wb_valid !== exp_valid || (exp_valid && (wb_des !== exp_des || wb_data !== exp_data))) begin
                n_fail++;
                $display("FAIL full_drain%0d got v=%b des=%0d data=%h want %b %0d %h",
                         i, wb_valid, wb_des, wb_data, exp_valid, exp_des, exp_data);
            end
        end
    endtask

    task automatic test_des_zero();
        idle_inputs();
        ll_valid = 1'b1; ll_des = 5'd0; ll_data = 32'hFFFF_0000;
        #1;
        n_checks++;
        if (ll_ready !== 1'b1) begin
            n_fail++; $display("FAIL des_zero_ready got %b want 1", ll_ready);
        end
        tick();
        ll_valid = 1'b0;
        tick();
        n_checks++;
        if (fifo_count !== '0 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL des_zero_drop got cnt=%0d v=%b want 0 0", fifo_count, wb_valid);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        pipe_valid = 1'b1; pipe_des = 5'd9; pipe_data = 32'h9;
        ll_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ll_des = 5'(1 + c); ll_data = $urandom;
            tick();
        end
        n_checks++;
        if (fifo_count !== CW'(3)) begin
            n_fail++; $display("FAIL reset_mid_fill got %0d want 3", fifo_count);
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        n_checks++;
        if (fifo_count !== '0 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_cycle got cnt=%0d v=%b want 0 0", fifo_count, wb_valid);
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (wb_valid !== 1'b0 || fifo_count !== '0) begin
                n_fail++; $display("FAIL reset_mid_after%0d got v=%b cnt=%0d want 0 0", c, wb_valid, fifo_count);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 79) == 0);
            pipe_valid = ($urandom_range(0, 99) < 65);
            pipe_des   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_data  = $urandom;
            ll_valid   = ($urandom_range(0, 99) < 45);
            ll_des     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ll_data    = $urandom;
            #1;
            n_checks++;
            if (ll_ready !== (!rst && q.size() != int'(DEPTH))) begin
                n_fail++; $display("FAIL rand_ready cyc%0d got %b want %b", c, ll_ready, !rst && q.size() != int'(DEPTH));
            end
            tick();
            n_checks++;
            if (wb_valid !== exp_valid || fifo_count !== CW'(q.size()) || starve_hold !== exp_hold ||
                (exp_valid && (wb_des !== exp_des || wb_data !== exp_data))) begin
                n_fail++;
                $display("FAIL rand_out cyc%0d got v=%b des=%0d data=%h cnt=%0d hold=%b want %b %0d %h %0d %b",
                         c, wb_valid, wb_des, wb_data, fifo_count, starve_hold,
                         exp_valid, exp_des, exp_data, q.size(), exp_hold);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_push();
        test_starve();
        test_full_pop();
        test_des_zero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
